timebase_rand_unit: RTL and testbench
=====================================

// Module: timebase_rand_unit
// PURPOSE
//  Clock-domain helper for the maze/VGA game top level, sitting beside the VGA timing and game logic.
//  Derives from in_clk (100 MHz): the 25 MHz pixel clock, two display/scan clocks, and 0.5 s / 1 s game clocks.
//  Also runs two maximal-length LFSRs (maze wall masks) and keeps 1 s snapshots of them.
//  All logic is clocked by in_clk only; derived clocks are registered square waves.
// PARAMETERS
//  DIV_A_HALF  50000       in_clk cycles per half-period of div_a_clk (scan/LFSR-B step clock)
//  DIV_B_HALF  40000       half-period of div_b_clk (LFSR-A step clock)
//  HSEC_HALF   25000000    half-period of half_sec_clk
//  SEC_HALF    50000000    half-period of sec_clk (1 Hz)
//  LFSR_BITS   25          LFSR width; legal range 3..32
//  LFSR_SEED   30504031    reset and default seed, LFSR_BITS wide
// PORTS
//  in_clk        in   1          system clock, 100 MHz
//  reset         in   1          asynchronous, active-high; clears everything below
//  lfsr_en       in   1          enables LFSR stepping
//  seed_load     in   1          loads seed_data into both LFSRs this cycle
//  seed_data     in   LFSR_BITS  seed value
//  clk_pix       out  1          in_clk/4, 50 % duty
//  div_a_clk     out  1          period 2*DIV_A_HALF
//  div_b_clk     out  1          period 2*DIV_B_HALF
//  half_sec_clk  out  1          period 2*HSEC_HALF
//  sec_clk       out  1          period 2*SEC_HALF
//  rand_a        out  LFSR_BITS  live LFSR A state
//  rand_b        out  LFSR_BITS  live LFSR B state
//  rand_a_snap   out  LFSR_BITS  rand_a sampled at each sec_clk rise
//  rand_b_snap   out  LFSR_BITS  rand_b sampled at each sec_clk rise
//  rand_a_done   out  1          1-cycle pulse: A stepped onto its current seed
//  rand_b_done   out  1          1-cycle pulse: B stepped onto its current seed
// BEHAVIOUR
//  Reset values:
//  - All divided clocks 0; all counters 0; done flags 0.
//  - rand_*, rand_*_snap, and the stored seed = LFSR_SEED.
//  clk_pix = bit 1 of a free-running 2-bit counter; first rises 2 cycles after reset release.
//  Divider:
//  - cnt counts 0..HALF-1; at HALF-1, cnt <= 0 and output toggles.
//  - rise_tick = 1-cycle internal pulse in the cycle the output goes 0->1.
//  LFSR (Fibonacci, XNOR):
//  - fb = ~XOR of the tap bits; q <= {q[N-2:0], fb}.
//  - Taps for 25 bits: 25,22; for 4 bits: 4,3.
//  - The all-ones state is the lock-up state and is never reached.
//  Stepping:
//  - A steps on div_b rise_tick when lfsr_en; B steps on div_a rise_tick when lfsr_en.
//  - seed_load has priority over a step in the same cycle.
//  - A seed_data of all ones is replaced by LFSR_SEED.
//  done: registered, high for one cycle after a step whose result equals the stored seed.
//  Snapshot: on sec_clk rise_tick, rand_*_snap <= the rand_* value present before that edge.
//  - An LFSR step in the same cycle does not affect the captured value.
//  reset mid-operation: immediate return to the reset values; dividers restart their phase.
// CONFIGURATION
//  TIMEBASE_RAND_B_EN defined: LFSR B, rand_b, rand_b_snap and rand_b_done are active.
//  Not defined: B is not built; rand_b, rand_b_snap and rand_b_done are tied to 0.
//  Dividers are unaffected in both cases.
// STRUCTURE
//  Package timebase_pkg holds:
//  - the tap-mask table for widths 3..32 (out-of-range LFSR_BITS is an elaboration error);
//  - the default LFSR_SEED and default divider constants.
//  Sub-modules:
//  - clk_div_half: counter + toggle + rise_tick, instantiated 4x;
//  - lfsr_core: step/load/done, instantiated 2x.
// TESTING
//  - Reset, then run 8 cycles -> clk_pix pattern 0,0,1,1,0,0,1,1; all other outputs at reset values.
//  - DIV_A_HALF=3 -> div_a_clk toggles every 3 cycles (period 6); reset asserted mid-period -> output 0 at once, restarts with a full half-period.
//  - LFSR_BITS=4, seed_load with seed_data 0, lfsr_en=1 -> steps 0001, 0011, 0111, 1110; period 15; 1111 never seen; done pulses once per 15 steps.
//  - seed_load and step tick in the same cycle -> state = seed_data; seed_data all ones -> state = LFSR_SEED.
//  - SEC_HALF=4, DIV_B_HALF=4 (same-cycle ticks) -> rand_a_snap equals pre-step rand_a.
//  - lfsr_en=0 -> rand_* frozen while dividers keep running.
//  - Without TIMEBASE_RAND_B_EN -> rand_b, rand_b_snap, rand_b_done stay 0.

Source files
------------

// File: rtl/timebase_pkg.sv
// rtl/timebase_pkg.sv - default divider/seed constants and LFSR tap-mask table for timebase_rand_unit
package timebase_pkg;

    localparam int          DEF_DIV_A_HALF = 50000;
    localparam int          DEF_DIV_B_HALF = 40000;
    localparam int          DEF_HSEC_HALF  = 25000000;
    localparam int          DEF_SEC_HALF   = 50000000;
    localparam int          DEF_LFSR_BITS  = 25;
    localparam logic [31:0] DEF_LFSR_SEED  = 32'd30504031;

    // Maximal-length XNOR taps; bit (t-1) set for tap t.
    function automatic logic [31:0] tap_mask(input int bits);
        case (bits)
            3:  return 32'h0000_0006;
            4:  return 32'h0000_000C;
            5:  return 32'h0000_0014;
            6:  return 32'h0000_0030;
            7:  return 32'h0000_0060;
            8:  return 32'h0000_00B8;
            9:  return 32'h0000_0110;
            10: return 32'h0000_0240;
            11: return 32'h0000_0500;
            12: return 32'h0000_0829;
            13: return 32'h0000_100D;
            14: return 32'h0000_2015;
            15: return 32'h0000_6000;
            16: return 32'h0000_D008;
            17: return 32'h0001_2000;
            18: return 32'h0002_0400;
            19: return 32'h0004_0023;
            20: return 32'h0009_0000;
            21: return 32'h0014_0000;
            22: return 32'h0030_0000;
            23: return 32'h0042_0000;
            24: return 32'h00E1_0000;
            25: return 32'h0120_0000;
            26: return 32'h0200_0023;
            27: return 32'h0400_0013;
            28: return 32'h0900_0000;
            29: return 32'h1400_0000;
            30: return 32'h2000_0029;
            31: return 32'h4800_0000;
            32: return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/clk_div_half.sv
// rtl/clk_div_half.sv - half-period counter driving a registered square wave plus a rise tick
module clk_div_half #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    output logic div_clk,
    output logic rise_tick
);

    localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            div_clk <= ~div_clk;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // High in the cycle whose closing edge drives div_clk 0->1.
    assign rise_tick = (cnt == LAST) && !div_clk;

endmodule

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - XNOR Fibonacci LFSR with seed load and return-to-seed done pulse
module lfsr_core #(
    parameter int           N    = 25,
    parameter logic [N-1:0] TAPS = '0,
    parameter logic [N-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic [N-1:0] load_data,
    output logic [N-1:0] q,
    output logic         done
);

    logic [N-1:0] seed_q;
    logic [N-1:0] next_q;
    logic [N-1:0] load_val;

    assign next_q   = {q[N-2:0], ~^(q & TAPS)};
    // All ones is the XNOR lock-up state, so it can never be accepted as a seed.
    assign load_val = (&load_data) ? SEED : load_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= SEED;
            seed_q <= SEED;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                q      <= load_val;
                seed_q <= load_val;
            end else if (step) begin
                q    <= next_q;
                done <= (next_q == seed_q);
            end
        end
    end

endmodule

// File: rtl/timebase_rand_unit.sv
// rtl/timebase_rand_unit.sv - derived game clocks and maze LFSRs; TIMEBASE_RAND_B_EN builds LFSR B
module timebase_rand_unit
    import timebase_pkg::*;
#(
    parameter int                   DIV_A_HALF = DEF_DIV_A_HALF,
    parameter int                   DIV_B_HALF = DEF_DIV_B_HALF,
    parameter int                   HSEC_HALF  = DEF_HSEC_HALF,
    parameter int                   SEC_HALF   = DEF_SEC_HALF,
    parameter int                   LFSR_BITS  = DEF_LFSR_BITS,
    parameter logic [LFSR_BITS-1:0] LFSR_SEED  = LFSR_BITS'(DEF_LFSR_SEED)
) (
    input  logic                 in_clk,
    input  logic                 reset,
    input  logic                 lfsr_en,
    input  logic                 seed_load,
    input  logic [LFSR_BITS-1:0] seed_data,
    output logic                 clk_pix,
    output logic                 div_a_clk,
    output logic                 div_b_clk,
    output logic                 half_sec_clk,
    output logic                 sec_clk,
    output logic [LFSR_BITS-1:0] rand_a,
    output logic [LFSR_BITS-1:0] rand_b,
    output logic [LFSR_BITS-1:0] rand_a_snap,
    output logic [LFSR_BITS-1:0] rand_b_snap,
    output logic                 rand_a_done,
    output logic                 rand_b_done
);

    generate
        if (LFSR_BITS < 3 || LFSR_BITS > 32) begin : g_bad_width
            $error("timebase_rand_unit: LFSR_BITS must be within 3..32");
        end
    endgenerate

    localparam logic [LFSR_BITS-1:0] TAPS = LFSR_BITS'(tap_mask(LFSR_BITS));

    logic [1:0] pix_cnt;
    logic       a_tick, b_tick, hsec_tick, sec_tick;
    logic       unused_ticks;

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) pix_cnt <= 2'd0;
        else       pix_cnt <= pix_cnt + 2'd1;
    end
    assign clk_pix = pix_cnt[1];

    clk_div_half #(.HALF(DIV_A_HALF)) u_div_a (.clk(in_clk), .rst(reset), .div_clk(div_a_clk),    .rise_tick(a_tick));
    clk_div_half #(.HALF(DIV_B_HALF)) u_div_b (.clk(in_clk), .rst(reset), .div_clk(div_b_clk),    .rise_tick(b_tick));
    clk_div_half #(.HALF(HSEC_HALF))  u_hsec  (.clk(in_clk), .rst(reset), .div_clk(half_sec_clk), .rise_tick(hsec_tick));
    clk_div_half #(.HALF(SEC_HALF))   u_sec   (.clk(in_clk), .rst(reset), .div_clk(sec_clk),      .rise_tick(sec_tick));

    lfsr_core #(.N(LFSR_BITS), .TAPS(TAPS), .SEED(LFSR_SEED)) u_lfsr_a (
        .clk(in_clk), .rst(reset), .step(b_tick & lfsr_en), .load(seed_load),
        .load_data(seed_data), .q(rand_a), .done(rand_a_done)
    );

    // Snapshot samples the pre-edge value, so a coincident step never leaks in.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset)         rand_a_snap <= LFSR_SEED;
        else if (sec_tick) rand_a_snap <= rand_a;
    end

`ifdef TIMEBASE_RAND_B_EN
    lfsr_core #(.N(LFSR_BITS), .TAPS(TAPS), .SEED(LFSR_SEED)) u_lfsr_b (
        .clk(in_clk), .rst(reset), .step(a_tick & lfsr_en), .load(seed_load),
        .load_data(seed_data), .q(rand_b), .done(rand_b_done)
    );

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset)         rand_b_snap <= LFSR_SEED;
        else if (sec_tick) rand_b_snap <= rand_b;
    end

    assign unused_ticks = hsec_tick;
`else
    assign rand_b       = '0;
    assign rand_b_snap  = '0;
    assign rand_b_done  = 1'b0;
    assign unused_ticks = ^{hsec_tick, a_tick};
`endif

endmodule

// File: tb/tb_timebase_rand_unit.sv
// tb/tb_timebase_rand_unit.sv - scoreboard bench for timebase_rand_unit with small dividers and a 4-bit LFSR
module tb_timebase_rand_unit;

    localparam logic [3:0] SEED = 4'b0101;

    logic       in_clk = 1'b0;
    logic       reset = 1'b1;
    logic       lfsr_en = 1'b0;
    logic       seed_load = 1'b0;
    logic [3:0] seed_data = 4'd0;
    logic       clk_pix, div_a_clk, div_b_clk, half_sec_clk, sec_clk;
    logic [3:0] rand_a, rand_b, rand_a_snap, rand_b_snap;
    logic       rand_a_done, rand_b_done;

    always #5 in_clk = ~in_clk;

    timebase_rand_unit #(
        .DIV_A_HALF(3), .DIV_B_HALF(4), .HSEC_HALF(5), .SEC_HALF(4),
        .LFSR_BITS(4), .LFSR_SEED(SEED)
    ) dut (
        .in_clk(in_clk), .reset(reset), .lfsr_en(lfsr_en), .seed_load(seed_load),
        .seed_data(seed_data), .clk_pix(clk_pix), .div_a_clk(div_a_clk),
        .div_b_clk(div_b_clk), .half_sec_clk(half_sec_clk), .sec_clk(sec_clk),
        .rand_a(rand_a), .rand_b(rand_b), .rand_a_snap(rand_a_snap),
        .rand_b_snap(rand_b_snap), .rand_a_done(rand_a_done), .rand_b_done(rand_b_done)
    );

    typedef struct packed {
        logic       pix, a, b, h, s;
        logic [3:0] ra, rb, sa, sb;
        logic       da, db;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    int         m_pix, m_ca, m_cb, m_ch, m_cs;
    bit         m_a, m_b, m_h, m_s, m_da, m_db, m_a_step;
    logic [3:0] m_ra, m_rb, m_sa, m_sb, m_seed_a, m_seed_b;

    function automatic logic [3:0] m_next(input logic [3:0] v);
        return {v[2:0], ~(v[3] ^ v[2])};
    endfunction

    task automatic model_reset();
        m_pix = 0; m_ca = 0; m_cb = 0; m_ch = 0; m_cs = 0;
        m_a = 0; m_b = 0; m_h = 0; m_s = 0; m_da = 0; m_db = 0; m_a_step = 0;
        m_ra = SEED; m_sa = SEED; m_seed_a = SEED; m_seed_b = SEED;
`ifdef TIMEBASE_RAND_B_EN
        m_rb = SEED; m_sb = SEED;
`else
        m_rb = 4'd0; m_sb = 4'd0;
`endif
    endtask

    task automatic model_clock(input bit en, input bit ld, input logic [3:0] d);
        bit         ta, tb, ts;
        logic [3:0] v;
        ta = (m_ca == 2) && !m_a;
        tb = (m_cb == 3) && !m_b;
        ts = (m_cs == 3) && !m_s;
        v  = (d == 4'hF) ? SEED : d;
        if (ts) begin m_sa = m_ra; m_sb = m_rb; end
        m_da = 0; m_a_step = 0;
        if (ld) begin m_ra = v; m_seed_a = v; end
        else if (tb && en) begin m_ra = m_next(m_ra); m_da = (m_ra == m_seed_a); m_a_step = 1; end
`ifdef TIMEBASE_RAND_B_EN
        m_db = 0;
        if (ld) begin m_rb = v; m_seed_b = v; end
        else if (ta && en) begin m_rb = m_next(m_rb); m_db = (m_rb == m_seed_b); end
`endif
        if (m_ca == 2) begin m_ca = 0; m_a = !m_a; end else m_ca++;
        if (m_cb == 3) begin m_cb = 0; m_b = !m_b; end else m_cb++;
        if (m_ch == 4) begin m_ch = 0; m_h = !m_h; end else m_ch++;
        if (m_cs == 3) begin m_cs = 0; m_s = !m_s; end else m_cs++;
        m_pix = (m_pix + 1) % 4;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.pix = m_pix[1]; e.a = m_a; e.b = m_b; e.h = m_h; e.s = m_s;
        e.ra = m_ra; e.rb = m_rb; e.sa = m_sa; e.sb = m_sb; e.da = m_da; e.db = m_db;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        check("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("clk_pix", clk_pix, e.pix);
            check("div_a_clk", div_a_clk, e.a);
            check("div_b_clk", div_b_clk, e.b);
            check("half_sec_clk", half_sec_clk, e.h);
            check("sec_clk", sec_clk, e.s);
            check("rand_a", rand_a, e.ra);
            check("rand_b", rand_b, e.rb);
            check("rand_a_snap", rand_a_snap, e.sa);
            check("rand_b_snap", rand_b_snap, e.sb);
            check("rand_a_done", rand_a_done, e.da);
            check("rand_b_done", rand_b_done, e.db);
        end
    endtask

    task automatic cycle(input bit en, input bit ld, input logic [3:0] d);
        lfsr_en = en; seed_load = ld; seed_data = d;
        model_clock(en, ld, d);
        sb_q.push_back(model_out());
        @(posedge in_clk);
        #1;
        compare_out();
    endtask

    initial begin
        bit [7:0]   pat;
        logic [3:0] seq [4];
        logic [3:0] pre;
        int         n, steps, dones;
        bit         saw_ones;
        pat = 8'b1100_1100;

        repeat (2) @(posedge in_clk);
        #1;
        model_reset();
        sb_q.push_back(model_out());
        compare_out();
        check("pix_pat0", clk_pix, pat[0]);
        reset = 1'b0;
        for (int i = 1; i < 8; i++) begin
            cycle(0, 0, 4'd0);
            check("pix_pat", clk_pix, pat[i]);
        end

        repeat (16) cycle(0, 0, 4'd0);
        check("frozen_a_initial", rand_a, SEED);
        check("frozen_snap_initial", rand_a_snap, SEED);

        n = 0;
        while (!(m_a && m_ca == 1) && n < 20) begin cycle(0, 0, 4'd0); n++; end
        check("wait_mid_period", 32'(n < 20), 1);
        check("pre_reset_div_a", div_a_clk, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_div_a", div_a_clk, 0);
        model_reset();
        sb_q.push_back(model_out());
        compare_out();
        @(negedge in_clk) reset = 1'b0;
        repeat (2) cycle(0, 0, 4'd0);
        check("div_a_hold", div_a_clk, 0);
        cycle(0, 0, 4'd0);
        check("div_a_rise", div_a_clk, 1);
        repeat (3) cycle(0, 0, 4'd0);
        check("div_a_fall", div_a_clk, 0);

        cycle(1, 1, 4'd0);
        check("load_zero", rand_a, 4'd0);
        steps = 0; dones = 0; saw_ones = 0; n = 0;
        while (steps < 15 && n < 400) begin
            cycle(1, 0, 4'd0);
            n++;
            if (m_a_step) begin
                if (steps < 4) seq[steps] = rand_a;
                steps++;
            end
            if (rand_a_done === 1'b1) dones++;
            if (rand_a === 4'hF) saw_ones = 1;
        end
        check("steps_reached", steps, 15);
        check("seq0", seq[0], 4'b0001);
        check("seq1", seq[1], 4'b0011);
        check("seq2", seq[2], 4'b0111);
        check("seq3", seq[3], 4'b1110);
        check("period15", rand_a, 4'd0);
        check("done_once", dones, 1);
        check("no_lockup", 32'(saw_ones), 0);

        n = 0;
        while (!(m_cb == 3 && !m_b) && n < 20) begin cycle(1, 0, 4'd0); n++; end
        check("wait_tick_load", 32'(n < 20), 1);
        cycle(1, 1, 4'hA);
        check("load_over_step", rand_a, 4'hA);
        n = 0;
        while (!(m_cb == 3 && !m_b) && n < 20) begin cycle(1, 0, 4'd0); n++; end
        check("wait_tick_ones", 32'(n < 20), 1);
        cycle(1, 1, 4'hF);
        check("ones_to_seed", rand_a, SEED);

        n = 0;
        while (!(m_cs == 3 && !m_s) && n < 20) begin cycle(1, 0, 4'd0); n++; end
        check("wait_sec_tick", 32'(n < 20), 1);
        pre = m_ra;
        cycle(1, 0, 4'd0);
        check("snap_pre_step", rand_a_snap, pre);
        check("snap_step_seen", 32'(rand_a != pre), 1);

        pre = m_ra;
        repeat (24) cycle(0, 0, 4'd0);
        check("freeze_a", rand_a, pre);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
